// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen: DVI/HDMI raster timing and test-pattern source, one pixel per clock.
// Walks a full raster of active area, front porch, sync and back porch on both axes.
// Every output is registered from the counter state, one cycle behind the counters.
//
// Ports:
//   clock        pixel clock
//   reset_n      asynchronous active-low reset
//   start        level; leaves IDLE and begins the raster
//   stop         pulse; halt after the current frame completes
//   mode         test pattern: 0 white, 1 colour bars, 2 checker, 3 ramp
//   red/green/blue  pixel colour, zero outside the active area
//   hsync/vsync  syncs, driven to HS_POL/VS_POL while asserted
//   de           data enable, high on active pixels
//   frame_start  one-cycle strobe with pixel (0,0)
//   busy         high while the raster is running
//
// Build option: define DVI_BORDER_EN to force a one-pixel white border
// around the active area in every mode.
module dvi_timing_gen #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned CNT_W    = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start,
  output logic       busy
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
`ifdef DVI_BORDER_EN
  localparam logic [CNT_W-1:0] H_EDGE   = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_EDGE   = CNT_W'(V_ACTIVE - 1);
`endif

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic [CNT_W-1:0] bar_px;   // pixel position inside the current colour bar
  logic [2:0]       bar_idx;  // colour bar index, tracked incrementally to avoid a divider
  logic             stop_req;
  logic [1:0]       mode_q;

  logic       at_origin;
  logic       at_last;
  logic       active;
  logic       hs_act;
  logic       vs_act;
  logic [1:0] mode_eff;
  logic [7:0] x8;
  logic [7:0] y8;
  logic [23:0] pat;
  logic [23:0] pix;

  // Pixel decode from the counter state.
  always_comb begin
    at_origin = (hcnt == '0) && (vcnt == '0);
    at_last   = (hcnt == H_LAST) && (vcnt == V_LAST);
    active    = (hcnt < H_ACT) && (vcnt < V_ACT);
    hs_act    = (hcnt >= HS_BEG) && (hcnt < HS_END);
    vs_act    = (vcnt >= VS_BEG) && (vcnt < VS_END);
    // mode is sampled live on the origin pixel, then held for the frame
    mode_eff  = at_origin ? mode : mode_q;
    x8        = 8'(hcnt);
    y8        = 8'(vcnt);
    pat       = 24'h000000;
    case (mode_eff)
      2'd0: pat = 24'hFFFFFF;
      2'd1: begin
        case (bar_idx)
          3'd0: pat = 24'hFFFFFF;
          3'd1: pat = 24'hFFFF00;
          3'd2: pat = 24'h00FFFF;
          3'd3: pat = 24'h00FF00;
          3'd4: pat = 24'hFF00FF;
          3'd5: pat = 24'hFF0000;
          3'd6: pat = 24'h0000FF;
          default: pat = 24'h000000;
        endcase
      end
      2'd2: pat = (x8[5] ^ y8[5]) ? 24'hFFFFFF : 24'h000000;
      default: pat = {x8, y8, x8 ^ y8};
    endcase
`ifdef DVI_BORDER_EN
    if ((hcnt == '0) || (hcnt == H_EDGE) || (vcnt == '0) || (vcnt == V_EDGE)) begin
      pat = 24'hFFFFFF;
    end
`endif
    pix = active ? pat : 24'h000000;
  end

  // Control state, raster counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      hcnt        <= '0;
      vcnt        <= '0;
      bar_px      <= '0;
      bar_idx     <= '0;
      stop_req    <= 1'b0;
      mode_q      <= 2'd0;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else if (state == ST_IDLE) begin
      hcnt        <= '0;
      vcnt        <= '0;
      bar_px      <= '0;
      bar_idx     <= '0;
      stop_req    <= 1'b0;
      red         <= 8'h00;
      green       <= 8'h00;
      blue        <= 8'h00;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
      busy        <= start;
      if (start) begin
        state <= ST_RUN;
      end
    end else begin
      {red, green, blue} <= pix;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
      de          <= active;
      frame_start <= at_origin;
      if (at_origin) begin
        mode_q <= mode;
      end
      if (stop_req && at_last) begin
        // last pixel of the final frame is blanking, so outputs already match idle
        state    <= ST_IDLE;
        busy     <= 1'b0;
        stop_req <= 1'b0;
        hcnt     <= '0;
        vcnt     <= '0;
        bar_px   <= '0;
        bar_idx  <= '0;
      end else begin
        busy     <= 1'b1;
        stop_req <= stop_req | stop;
        if (hcnt == H_LAST) begin
          hcnt    <= '0;
          bar_px  <= '0;
          bar_idx <= 3'd0;
          vcnt    <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
          if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_px <= bar_px + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: two instances (active-high and active-low syncs) driven
// with random start/stop/mode and compared every cycle against a pixel-index model.
module tb_dvi_timing_gen;

  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = 25;
  localparam int VT = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [1:0] mode;

  logic [7:0] red_p, green_p, blue_p, red_n, green_n, blue_n;
  logic       hsync_p, vsync_p, de_p, fs_p, busy_p;
  logic       hsync_n, vsync_n, de_n, fs_n, busy_n;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(12)
  ) u_pos (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .red(red_p), .green(green_p), .blue(blue_p), .hsync(hsync_p), .vsync(vsync_p),
    .de(de_p), .frame_start(fs_p), .busy(busy_p)
  );

  dvi_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
  ) u_neg (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .red(red_n), .green(green_n), .blue(blue_n), .hsync(hsync_n), .vsync(vsync_n),
    .de(de_n), .frame_start(fs_n), .busy(busy_n)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected colour of raster position (x,y) under pattern md.
  function automatic logic [23:0] pixel(input int x, input int y, input logic [1:0] md);
    logic [23:0] bars [8];
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    if (!(x < HA && y < VA)) return 24'h000000;
`ifdef DVI_BORDER_EN
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 24'hFFFFFF;
`endif
    case (md)
      2'd0: return 24'hFFFFFF;
      2'd1: return bars[x / (HA / 8)];
      2'd2: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
      default: return {8'(x), 8'(y), 8'(x ^ y)};
    endcase
  endfunction

  // Model: the raster is a linear pixel index p; position is p mod H_TOTAL and line mod V_TOTAL.
  bit          m_run, m_stopreq;
  int          m_p, mx, my;
  logic [1:0]  m_mode, m_md;
  logic [23:0] e_rgb;
  bit          e_hs, e_vs, e_de, e_fs, e_busy;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_run = 0; m_stopreq = 0; m_p = 0; m_mode = 2'd0;
      e_rgb = 24'h0; e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_busy = 0;
    end else if (!m_run) begin
      e_rgb = 24'h0; e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_busy = 0;
      if (start) begin
        m_run = 1; m_p = 0; e_busy = 1;
      end
    end else begin
      mx = m_p % HT;
      my = m_p / HT;
      m_md = (mx == 0 && my == 0) ? mode : m_mode;
      if (mx == 0 && my == 0) m_mode = mode;
      e_rgb = pixel(mx, my, m_md);
      e_de  = (mx < HA) && (my < VA);
      e_hs  = (mx >= HA + HF) && (mx < HA + HF + HS);
      e_vs  = (my >= VA + VF) && (my < VA + VF + VS);
      e_fs  = (mx == 0 && my == 0);
      if (m_stopreq && mx == HT - 1 && my == VT - 1) begin
        m_run = 0; m_stopreq = 0; e_busy = 0;
      end else begin
        if (stop) m_stopreq = 1;
        m_p = (m_p + 1) % (HT * VT);
        e_busy = 1;
      end
    end
  end

  // Per-frame statistics and literal pixel pins, derived from the DUT's own frame_start.
  int         since_fs = 0, de_c = 0, hs_c = 0, vs_c = 0, px = 0;
  bit         have_prev = 0, in_frame = 0;
  logic [1:0] f_mode = 2'd0;
  logic [23:0] bar_lit [8];
  initial begin
    bar_lit[0] = 24'hFFFFFF; bar_lit[1] = 24'hFFFF00; bar_lit[2] = 24'h00FFFF; bar_lit[3] = 24'h00FF00;
    bar_lit[4] = 24'hFF00FF; bar_lit[5] = 24'hFF0000; bar_lit[6] = 24'h0000FF; bar_lit[7] = 24'h000000;
  end

  // Single compare process: model vs both instances every cycle, then frame-level pins.
  always @(negedge clock) begin
    check("out_pos", 32'({red_p, green_p, blue_p, hsync_p, vsync_p, de_p, fs_p, busy_p}),
          32'({e_rgb, e_hs, e_vs, e_de, e_fs, e_busy}));
    check("out_neg", 32'({red_n, green_n, blue_n, hsync_n, vsync_n, de_n, fs_n, busy_n}),
          32'({e_rgb, ~e_hs, ~e_vs, e_de, e_fs, e_busy}));
    since_fs++;
    px++;
    if (fs_p) begin
      if (have_prev) begin
        check("fs_period", 32'(since_fs), 32'd200);
        check("de_per_frame", 32'(de_c), 32'd64);
        check("hs_per_frame", 32'(hs_c), 32'd24);
        check("vs_per_frame", 32'(vs_c), 32'd50);
      end
      have_prev = 1; in_frame = 1;
      since_fs = 0; de_c = 0; hs_c = 0; vs_c = 0; px = 0;
      f_mode = m_mode;
    end
    if (!busy_p) begin
      have_prev = 0; in_frame = 0;
    end
    de_c += int'(de_p);
    hs_c += int'(hsync_p);
    vs_c += int'(vsync_p);
    if (in_frame) begin
`ifndef DVI_BORDER_EN
      if (f_mode == 2'd1 && px < 16) check("bar_line0", 32'({red_p, green_p, blue_p}), 32'(bar_lit[px / 2]));
      if (f_mode == 2'd3 && px == 50) check("ramp_0_2", 32'({red_p, green_p, blue_p}), 32'h000202);
`else
      if (f_mode == 2'd3 && px == 50) check("border_0_2", 32'({red_p, green_p, blue_p}), 32'hFFFFFF);
`endif
      if (f_mode == 2'd3 && px == 55) check("ramp_5_2", 32'({red_p, green_p, blue_p}), 32'h050207);
      if (f_mode == 2'd0 && px == 30) check("white_5_1", 32'({red_p, green_p, blue_p}), 32'hFFFFFF);
      if (f_mode == 2'd2 && px == 30) check("checker_5_1", 32'({red_p, green_p, blue_p}), 32'h000000);
    end
  end

  task automatic check_idle(input string nm);
    check(nm, 32'({red_p, green_p, blue_p, hsync_p, vsync_p, de_p, fs_p, busy_p, hsync_n, vsync_n}),
          32'({24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));
  endtask

  // Start from IDLE and pin the two-edge latency to the first active pixel.
  task automatic start_and_check();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    check("busy_rise", 32'({busy_p, fs_p, de_p}), 32'b100);
    @(posedge clock); #1;
    check("fs_latency", 32'({fs_p, de_p, busy_p}), 32'b111);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_busy_low(input int lim);
    int n = 0;
    while (busy_p && n < lim) begin
      @(negedge clock);
      n++;
    end
    check("busy_fall", 32'(busy_p), 32'd0);
  endtask

  task automatic wait_de(input int lim);
    int n = 0;
    while (!de_p && n < lim) begin
      @(negedge clock);
      n++;
    end
    check("de_seen", 32'(de_p), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clock);
    check_idle("reset_vals");
    reset_n = 1'b1;
    @(negedge clock);
    check_idle("idle_after_reset");

    // colour bars, with start left toggling while running (ignored)
    mode = 2'd1;
    start_and_check();
    repeat (400) begin
      @(negedge clock);
      start = 1'($urandom);
    end
    // ramp
    mode = 2'd3;
    repeat (400) @(negedge clock);
    // white, then switch to checker mid-frame
    mode = 2'd0;
    repeat (250) @(negedge clock);
    repeat (100) @(negedge clock);
    mode = 2'd2;
    repeat (300) @(negedge clock);

    // random modes and start levels
    repeat (1500) begin
      @(negedge clock);
      mode  = 2'($urandom);
      start = 1'($urandom);
    end

    // stop mid-frame: frame completes, then idle
    start = 1'b0;
    repeat ($urandom_range(20, 150)) @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_busy_low(400);
    repeat (3) @(negedge clock);
    check_idle("idle_after_stop");
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    repeat (2) @(negedge clock);
    check_idle("stop_while_idle");

    // async reset in the middle of an active line
    mode = 2'd0;
    start_and_check();
    repeat (60) @(negedge clock);
    wait_de(250);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    start_and_check();

    // random traffic with occasional stop pulses and restarts
    repeat (3000) begin
      @(negedge clock);
      mode  = 2'($urandom);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 299) == 0);
    end
    stop = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
